// File: rtl/bomberman_pkg.sv
// bomberman_pkg: shared button indices, default timing and repeat FSM encoding
package bomberman_pkg;
  localparam int BTN_L = 0;
  localparam int BTN_U = 1;
  localparam int BTN_D = 2;
  localparam int BTN_R = 3;
  localparam int BTN_C = 4;
  localparam int N_BTN = 5;
  localparam int DEF_DB_W = 20;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_RPT_W = 26;
  localparam int DEF_REPEAT_DELAY = 25000000;
  localparam int DEF_REPEAT_PERIOD = 10000000;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DELAY = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;
endpackage

// File: rtl/button_channel.sv
// button_channel: synchroniser, debouncer, edge pulses and auto-repeat for one button
module button_channel
  import bomberman_pkg::*;
#(
  parameter int DB_W = DEF_DB_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int RPT_W = DEF_RPT_W,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic rptEn,
  output logic btnLevel,
  output logic btnPress,
  output logic btnRelease,
  output logic btnRepeat
);
  logic s1, s2, flip, rptHit;
  logic [DB_W-1:0] dbCnt;
  logic [RPT_W-1:0] rptCnt;
  logic [1:0] state;
  always_comb begin
    flip = (s2 != btnLevel) && (dbCnt == DB_W'(DEBOUNCE_CYCLES - 1));
    rptHit = btnLevel && ((state == IDLE) ? btnPress :
             rptEn && (rptCnt == RPT_W'(((state == DELAY) ? REPEAT_DELAY : REPEAT_PERIOD) - 1)));
  end
  assign btnRepeat = rptHit;
  always_ff @(posedge clk) begin
    if (rst) begin
      {s2, s1} <= 2'b00;
      dbCnt <= '0;
      btnLevel <= 1'b0;
      btnPress <= 1'b0;
      btnRelease <= 1'b0;
      state <= IDLE;
      rptCnt <= '0;
    end else begin
      {s2, s1} <= {s1, raw};
      dbCnt <= (s2 == btnLevel || flip) ? '0 : dbCnt + 1'b1;
      if (flip) btnLevel <= s2;
      btnPress <= flip & s2;
      btnRelease <= flip & ~s2;
      if (!btnLevel) begin
        state <= IDLE;
        rptCnt <= '0;
      end else if (state == IDLE) begin
        if (btnPress) state <= DELAY;
        rptCnt <= '0;
      end else begin
        // a disabled channel parks its interval at zero so re-enabling restarts it
        rptCnt <= (!rptEn || rptHit) ? '0 : rptCnt + 1'b1;
        if (rptHit) state <= REPEAT;
      end
    end
  end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: N_BTN independent button channels plus any_press summary
module button_conditioner #(
  parameter int N_BTN = bomberman_pkg::N_BTN,
  parameter int DB_W = bomberman_pkg::DEF_DB_W,
  parameter int DEBOUNCE_CYCLES = bomberman_pkg::DEF_DEBOUNCE_CYCLES,
  parameter int RPT_W = bomberman_pkg::DEF_RPT_W,
  parameter int REPEAT_DELAY = bomberman_pkg::DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = bomberman_pkg::DEF_REPEAT_PERIOD
) (
  input  logic             ClkPort,
  input  logic             Reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_BTN-1:0] rpt_en,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_repeat,
  output logic             any_press
);
  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_channel #(
      .DB_W(DB_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RPT_W(RPT_W),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk(ClkPort),
      .rst(Reset),
      .raw(btn_raw[i]),
      .rptEn(rpt_en[i]),
      .btnLevel(btn_level[i]),
      .btnPress(btn_press[i]),
      .btnRelease(btn_release[i]),
      .btnRepeat(btn_repeat[i])
    );
  end
  assign any_press = |btn_press;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3
module tb_button_conditioner;
  import bomberman_pkg::*;
  logic ClkPort = 1'b0;
  logic Reset = 1'b1;
  logic [4:0] btn_raw = '0;
  logic [4:0] rpt_en = '0;
  logic [4:0] btn_level, btn_press, btn_release, btn_repeat;
  logic any_press;
  int tests = 0;
  int fails = 0;

  button_conditioner #(
    .N_BTN(5), .DB_W(20), .DEBOUNCE_CYCLES(4),
    .RPT_W(26), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .ClkPort(ClkPort), .Reset(Reset), .btn_raw(btn_raw), .rpt_en(rpt_en),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .any_press(any_press)
  );

  always #5 ClkPort = ~ClkPort;

  task automatic tick;
    @(posedge ClkPort);
    #1;
  endtask

  task automatic test_reset;
    logic [4:0] e;
    Reset = 1'b1;
    btn_raw = '1;
    rpt_en = '0;
    repeat (3) tick;
    tests++;
    if ({btn_level, btn_press, btn_release, btn_repeat, any_press} !== 21'b0) begin
      fails++;
      $display("FAIL reset_outputs: got lvl=%b prs=%b rel=%b rpt=%b any=%b, want all 0",
               btn_level, btn_press, btn_release, btn_repeat, any_press);
    end
    Reset = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick;
      e = (t == 6) ? 5'b11111 : 5'b00000;
      tests++;
      if (btn_press !== e || any_press !== (t == 6) || btn_repeat !== e) begin
        fails++;
        $display("FAIL held_through_reset_press t=%0d: got prs=%b any=%b rpt=%b, want %b",
                 t, btn_press, any_press, btn_repeat, e);
      end
      e = (t >= 6) ? 5'b11111 : 5'b00000;
      tests++;
      if (btn_level !== e) begin
        fails++;
        $display("FAIL held_through_reset_level t=%0d: got %b want %b", t, btn_level, e);
      end
    end
    btn_raw = '0;
    for (int t = 1; t <= 8; t++) begin
      tick;
      e = (t == 6) ? 5'b11111 : 5'b00000;
      tests++;
      if (btn_release !== e || btn_level !== ~((t >= 6) ? 5'b11111 : 5'b00000) || btn_repeat !== 5'b0) begin
        fails++;
        $display("FAIL release_all t=%0d: got rel=%b lvl=%b rpt=%b, want rel=%b",
                 t, btn_release, btn_level, btn_repeat, e);
      end
    end
  endtask

  task automatic test_glitch;
    btn_raw[BTN_L] = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      tick;
      if (t == 3) btn_raw[BTN_L] = 1'b0;
      tests++;
      if (btn_level !== 5'b0 || btn_press !== 5'b0 || btn_repeat !== 5'b0) begin
        fails++;
        $display("FAIL glitch t=%0d: got lvl=%b prs=%b rpt=%b, want 0",
                 t, btn_level, btn_press, btn_repeat);
      end
    end
  endtask

  task automatic test_repeat;
    logic [4:0] eP, eR, eRel, eL;
    rpt_en = 5'b00010;
    btn_raw[BTN_U] = 1'b1;
    for (int t = 1; t <= 52; t++) begin
      tick;
      if (t == 40) btn_raw[BTN_U] = 1'b0;
      eP = (t == 6) ? 5'b00010 : 5'b0;
      eR = (t == 6 || (t >= 16 && t < 46 && (t - 16) % 3 == 0)) ? 5'b00010 : 5'b0;
      eRel = (t == 46) ? 5'b00010 : 5'b0;
      eL = (t >= 6 && t < 46) ? 5'b00010 : 5'b0;
      tests++;
      if (btn_press !== eP || btn_repeat !== eR || btn_release !== eRel || btn_level !== eL) begin
        fails++;
        $display("FAIL repeat_stream t=%0d: got prs=%b rpt=%b rel=%b lvl=%b, want %b %b %b %b",
                 t, btn_press, btn_repeat, btn_release, btn_level, eP, eR, eRel, eL);
      end
    end
    rpt_en = '0;
  endtask

  task automatic test_rpt_en;
    logic [4:0] eP, eR, eRel, eL;
    rpt_en = '0;
    btn_raw[BTN_U] = 1'b1;
    for (int t = 1; t <= 56; t++) begin
      tick;
      if (t == 27) rpt_en[BTN_U] = 1'b1;
      if (t == 45) btn_raw[BTN_U] = 1'b0;
      eP = (t == 6) ? 5'b00010 : 5'b0;
      eR = (t == 6 || (t >= 36 && t < 51 && (t - 36) % 3 == 0)) ? 5'b00010 : 5'b0;
      eRel = (t == 51) ? 5'b00010 : 5'b0;
      eL = (t >= 6 && t < 51) ? 5'b00010 : 5'b0;
      tests++;
      if (btn_press !== eP || btn_repeat !== eR || btn_release !== eRel || btn_level !== eL) begin
        fails++;
        $display("FAIL rpt_en_gate t=%0d: got prs=%b rpt=%b rel=%b lvl=%b, want %b %b %b %b",
                 t, btn_press, btn_repeat, btn_release, btn_level, eP, eR, eRel, eL);
      end
    end
    rpt_en = '0;
  endtask

  task automatic test_reset_mid;
    logic [4:0] eP, eR, eL;
    rpt_en = 5'b00100;
    btn_raw[BTN_D] = 1'b1;
    for (int t = 1; t <= 41; t++) begin
      tick;
      if (t == 20) Reset = 1'b1;
      if (t == 21) begin
        Reset = 1'b0;
        tests++;
        if ({btn_level, btn_press, btn_release, btn_repeat, any_press} !== 21'b0) begin
          fails++;
          $display("FAIL reset_mid_outputs: got lvl=%b prs=%b rel=%b rpt=%b any=%b, want all 0",
                   btn_level, btn_press, btn_release, btn_repeat, any_press);
        end
      end else begin
        eP = (t == 6 || t == 27) ? 5'b00100 : 5'b0;
        eR = (t == 6 || t == 16 || t == 19 || t == 27 || (t >= 37 && (t - 37) % 3 == 0)) ? 5'b00100 : 5'b0;
        eL = ((t >= 6 && t <= 20) || t >= 27) ? 5'b00100 : 5'b0;
        tests++;
        if (btn_press !== eP || btn_repeat !== eR || btn_level !== eL) begin
          fails++;
          $display("FAIL reset_mid_stream t=%0d: got prs=%b rpt=%b lvl=%b, want %b %b %b",
                   t, btn_press, btn_repeat, btn_level, eP, eR, eL);
        end
      end
    end
    btn_raw = '0;
    repeat (10) tick;
    rpt_en = '0;
  endtask

  task automatic test_simultaneous;
    logic [4:0] eP, eR, eRel, eL;
    rpt_en = 5'b11000;
    btn_raw = 5'b11000;
    for (int t = 1; t <= 33; t++) begin
      tick;
      if (t == 12) btn_raw[BTN_C] = 1'b0;
      if (t == 25) btn_raw[BTN_R] = 1'b0;
      eP = (t == 6) ? 5'b11000 : 5'b0;
      eR[4] = (t == 6 || t == 16);
      eR[3] = (t == 6 || (t >= 16 && t < 31 && (t - 16) % 3 == 0));
      eR[2:0] = 3'b0;
      eRel = {t == 18, t == 31, 3'b0};
      eL = {t >= 6 && t < 18, t >= 6 && t < 31, 3'b0};
      tests++;
      if (btn_press !== eP || any_press !== (t == 6) || btn_repeat !== eR ||
          btn_release !== eRel || btn_level !== eL) begin
        fails++;
        $display("FAIL simultaneous t=%0d: got prs=%b any=%b rpt=%b rel=%b lvl=%b, want %b %b %b %b %b",
                 t, btn_press, any_press, btn_repeat, btn_release, btn_level,
                 eP, t == 6, eR, eRel, eL);
      end
    end
    rpt_en = '0;
  endtask

  initial begin
    test_reset;
    test_glitch;
    test_repeat;
    repeat (4) tick;
    test_rpt_en;
    repeat (4) tick;
    test_reset_mid;
    test_simultaneous;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
